// File: rtl/shift_ser_ctrl_pkg.sv
// Shared encodings for the shift_ser_ctrl serializer/deserializer slice:
// shift-register command codes and controller state codes.
package shift_ser_ctrl_pkg;

  // Shift-register command (S) encodings
  localparam logic [1:0] S_NO_CHANGE     = 2'b00;
  localparam logic [1:0] S_SHIFT_RIGHT   = 2'b01;
  localparam logic [1:0] S_SHIFT_LEFT    = 2'b10;
  localparam logic [1:0] S_PARALLEL_LOAD = 2'b11;

  // Controller state codes
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Shift command for the configured bit order: LSB first shifts right,
  // MSB first shifts left.
  function automatic logic [1:0] shift_cmd(input logic dir);
    return dir ? S_SHIFT_LEFT : S_SHIFT_RIGHT;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load.
// Shift right inserts si at the MSB; shift left inserts si at the LSB.
module shift_reg
  import shift_ser_ctrl_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [1:0]      s,
  input  logic            si,
  input  logic [SIZE-1:0] pi,
  output logic [SIZE-1:0] q
);

  // Register update selected by the S command
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else begin
      case (s)
        S_SHIFT_RIGHT:   q <= {si, q[SIZE-1:1]};
        S_SHIFT_LEFT:    q <= {q[SIZE-2:0], si};
        S_PARALLEL_LOAD: q <= pi;
        default:         q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_ser_ctrl.sv
// Sequencer driving one shift_reg as a serializer (TX) or deserializer (RX).
// A job runs IDLE -> SHIFT (SIZE cycles) -> DONE -> IDLE; abort returns to
// IDLE with the register frozen and without a completion pulse.
module shift_ser_ctrl
  import shift_ser_ctrl_pkg::*;
#(
  parameter int SIZE = 8,
  parameter bit DIR  = 1'b0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            mode,
  input  logic            abort,
  input  logic [SIZE-1:0] din,
  input  logic            sdi,
  output logic            ready,
  output logic            sdo,
  output logic            sdo_vld,
  output logic [SIZE-1:0] dout,
  output logic            done,
  output logic            dout_vld
);

  localparam int            CW       = $clog2(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic            accept;
  logic [1:0]      sr_s;
  logic            sr_si;
  logic [SIZE-1:0] q;

  // abort outranks start, so a cancelled cycle never accepts a job
  assign accept = (state == ST_IDLE) && start && !abort;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (abort)                 state_nxt = ST_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, bit counter and mode latch; counter restarts whenever SHIFT is left
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_SHIFT) && (state_nxt == ST_SHIFT)) cnt <= cnt + 1'b1;
      else                                                cnt <= '0;
      if (accept) mode_q <= mode;
    end
  end

  // Shift-register command decode; TX loads din in the accepting cycle
  always_comb begin
    sr_s  = S_NO_CHANGE;
    sr_si = 1'b0;
    case (state)
      ST_IDLE:  if (accept && !mode) sr_s = S_PARALLEL_LOAD;
      ST_SHIFT: begin
        if (!abort) sr_s = shift_cmd(DIR);
        sr_si = mode_q ? sdi : 1'b0;
      end
      default:  sr_s = S_NO_CHANGE;
    endcase
  end

  shift_reg #(.SIZE(SIZE)) u_sreg (
    .clk  (clk),
    .rstn (rstn),
    .s    (sr_s),
    .si   (sr_si),
    .pi   (din),
    .q    (q)
  );

  assign ready    = (state == ST_IDLE);
  assign sdo_vld  = (state == ST_SHIFT) && !mode_q;
  assign sdo      = sdo_vld & (DIR ? q[SIZE-1] : q[0]);
  assign done     = (state == ST_DONE) && !abort;
  assign dout_vld = done && mode_q;
  assign dout     = q;

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Directed bench for shift_ser_ctrl: one LSB-first and one MSB-first
// instance driven by the same client and serial stimulus.
module tb_shift_ser_ctrl;

  logic       clk = 1'b0;
  logic       rstn, start, mode, abort, sdi;
  logic [7:0] din;

  logic       ready0, sdo0, sdo_vld0, done0, dout_vld0;
  logic [7:0] dout0;
  logic       ready1, sdo1, sdo_vld1, done1, dout_vld1;
  logic [7:0] dout1;

  int checks   = 0;
  int failures = 0;
  int dones;

  logic [7:0] tx_bits;
  logic [7:0] rx_a;
  logic [7:0] rx_b;

  always #5 clk = ~clk;

  shift_ser_ctrl #(.SIZE(8), .DIR(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .abort(abort),
    .din(din), .sdi(sdi), .ready(ready0), .sdo(sdo0), .sdo_vld(sdo_vld0),
    .dout(dout0), .done(done0), .dout_vld(dout_vld0)
  );

  shift_ser_ctrl #(.SIZE(8), .DIR(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .abort(abort),
    .din(din), .sdi(sdi), .ready(ready1), .sdo(sdo1), .sdo_vld(sdo_vld1),
    .dout(dout1), .done(done1), .dout_vld(dout_vld1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // bit i = i-th bit on the wire
    tx_bits = 8'hA5;   // 1,0,1,0,0,1,0,1
    rx_a    = 8'h53;   // 1,1,0,0,1,0,1,0
    rx_b    = 8'hA5;   // 1,0,1,0,0,1,0,1

    rstn = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; din = '0; sdi = 1'b0;
    repeat (2) tick();
    chk("rst_ready0", ready0, 1);
    chk("rst_ready1", ready1, 1);
    chk("rst_done0", done0, 0);
    chk("rst_sdo_vld0", sdo_vld0, 0);
    chk("rst_dout0", dout0, 0);
    rstn = 1'b1;
    tick();

    // TX A5: both bit orders put 1,0,1,0,0,1,0,1 on the wire
    start = 1'b1; mode = 1'b0; din = 8'hA5;
    tick();
    start = 1'b0; din = '0;
    for (int i = 0; i < 8; i++) begin
      chk("tx_sdo0", sdo0, tx_bits[i]);
      chk("tx_sdo1", sdo1, tx_bits[i]);
      chk("tx_sdo_vld0", sdo_vld0, 1);
      chk("tx_done0", done0, 0);
      tick();
    end
    chk("tx_done0_c9", done0, 1);
    chk("tx_done1_c9", done1, 1);
    chk("tx_dout_vld0_c9", dout_vld0, 0);
    chk("tx_ready0_c9", ready0, 0);
    chk("tx_sdo_vld0_c9", sdo_vld0, 0);
    tick();
    chk("tx_ready0_c10", ready0, 1);
    chk("tx_done0_c10", done0, 0);

    // RX of stream 1,1,0,0,1,0,1,0
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sdi = rx_a[i];
      chk("rx_sdo_vld0", sdo_vld0, 0);
      chk("rx_sdo0", sdo0, 0);
      chk("rx_done0", done0, 0);
      tick();
    end
    chk("rx_done0", done0, 1);
    chk("rx_dout_vld0", dout_vld0, 1);
    chk("rx_dout_vld1", dout_vld1, 1);
    chk("rx_dout0", dout0, 8'h53);
    chk("rx_dout1", dout1, 8'hCA);
    tick();
    chk("rx_ready0_after", ready0, 1);
    chk("rx_dout_vld0_after", dout_vld0, 0);

    // Abort a TX job at cnt=3
    start = 1'b1; mode = 1'b0; din = 8'h3C;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("ab_sdo_vld0_cnt3", sdo_vld0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_ready0", ready0, 1);
    chk("ab_done0", done0, 0);
    chk("ab_sdo_vld0", sdo_vld0, 0);
    chk("ab_dout0", dout0, 8'h07);
    chk("ab_dout1", dout1, 8'hE0);
    tick();
    chk("ab_dout0_hold", dout0, 8'h07);
    chk("ab_done0_hold", done0, 0);

    // RX of 1,0,1,0,0,1,0,1 with start held during the job (ignored)
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      sdi = rx_b[i];
      if (i >= 1) begin
        start = 1'b1; mode = 1'b0; din = 8'hFF;
      end
      if (done0) dones++;
      tick();
    end
    if (done0) dones++;
    chk("ign_done0", done0, 1);
    chk("ign_dout_vld0", dout_vld0, 1);
    chk("ign_dout0", dout0, 8'hA5);
    chk("ign_dout1", dout1, 8'hA5);
    din = 8'hA5;
    tick();
    if (done0) dones++;
    chk("ign_ready0", ready0, 1);
    chk("ign_done_count", dones, 1);

    // start still high in the first ready cycle: back-to-back TX accepted
    tick();
    start = 1'b0;
    chk("b2b_ready0", ready0, 0);
    chk("b2b_sdo_vld0", sdo_vld0, 1);
    chk("b2b_sdo0", sdo0, 1);
    repeat (8) tick();
    chk("b2b_done0_pre", done0, 1);
    abort = 1'b1;
    #1;
    chk("b2b_abort_done0", done0, 0);
    chk("b2b_abort_dout_vld0", dout_vld0, 0);
    tick();
    abort = 1'b0;
    chk("b2b_abort_ready0", ready0, 1);

    // abort outranks start in IDLE
    start = 1'b1; abort = 1'b1; mode = 1'b0; din = 8'h5A;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("prio_ready0", ready0, 1);
    chk("prio_sdo_vld0", sdo_vld0, 0);

    // Reset in the middle of a TX job
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("mid_ready0_busy", ready0, 0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready0", ready0, 1);
    chk("mid_rst_done0", done0, 0);
    chk("mid_rst_sdo_vld0", sdo_vld0, 0);
    chk("mid_rst_dout0", dout0, 0);
    chk("mid_rst_dout1", dout1, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("mid_rst_ready0_after", ready0, 1);
    chk("mid_rst_done0_after", done0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
